// File: rtl/ro_freq_counter_pkg.sv
// Shared types and default constants for the ring-oscillator frequency counter.
package ro_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } ro_state_e;

  localparam int unsigned RO_SETTLE_DEF = 32'd8;
  localparam int unsigned RO_WINDOW_DEF = 32'd1024;
  localparam int unsigned RO_CNT_W_DEF  = 32'd16;
  localparam int unsigned RO_STAGES     = 32'd19;

endpackage

// File: rtl/ro_freq_counter_if.sv
// Result handshake bundle of the frequency counter; RO_SNAPSHOT_EN adds the
// stage-buffer snapshot alongside the count.
interface ro_freq_counter_if #(
  parameter int unsigned CNT_W = 16
);
  import ro_pkg::*;

  logic             result_valid;
  logic             result_ready;
  logic [CNT_W-1:0] result_count;
  logic             result_ovf;
`ifdef RO_SNAPSHOT_EN
  logic [RO_STAGES-1:0] result_snapshot;

  modport master (output result_valid, result_count, result_ovf, result_snapshot, input result_ready);
  modport slave  (input result_valid, result_count, result_ovf, result_snapshot, output result_ready);
`else
  modport master (output result_valid, result_count, result_ovf, input result_ready);
  modport slave  (input result_valid, result_count, result_ovf, output result_ready);
`endif

endinterface

// File: rtl/ro_sync_edge.sv
// Two-flop synchronizer for the oscillator output plus a delay flop that
// turns each synchronized rising edge into a one-cycle pulse.
module ro_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Synchronizer and delay chain, running in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= async_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: settle, gate a fixed window, return the
// edge count over a valid/ready handshake. Optional macro: RO_SNAPSHOT_EN.
module ro_freq_counter
  import ro_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = RO_SETTLE_DEF,
  parameter int unsigned WINDOW_CYCLES = RO_WINDOW_DEF,
  parameter int unsigned CNT_W         = RO_CNT_W_DEF,
  parameter int unsigned TMR_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic ro_out,
  output logic ro_activate,
  output logic busy,
`ifdef RO_SNAPSHOT_EN
  input  logic [RO_STAGES-1:0] stage_buf,
`endif
  ro_freq_counter_if.master res
);

  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 32'd1);
  localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  ro_state_e        state_r, state_nx_s;
  logic [TMR_W-1:0] timer_r, timer_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic             ovf_r, ovf_nx_s;
  logic             edge_s;
  logic             ro_activate_r, busy_r, valid_r, res_ovf_r;
  logic [CNT_W-1:0] res_count_r;
`ifdef RO_SNAPSHOT_EN
  logic [RO_STAGES-1:0] snap_r;
`endif

  ro_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ro_out),
    .rise     (edge_s)
  );

  // Next-state, timer and edge-counter logic
  always_comb begin
    state_nx_s = state_r;
    timer_nx_s = timer_r;
    cnt_nx_s   = cnt_r;
    ovf_nx_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = WARMUP;
          timer_nx_s = SETTLE_LOAD;
          cnt_nx_s   = {CNT_W{1'b0}};
          ovf_nx_s   = 1'b0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WARMUP: begin
        if (abort) begin
          state_nx_s = IDLE;
        end else if (timer_r == {TMR_W{1'b0}}) begin
          state_nx_s = MEASURE;
          timer_nx_s = WINDOW_LOAD;
        end else begin
          timer_nx_s = timer_r - TMR_W'(1);
        end
      end
      MEASURE: begin
        // The expiry cycle's edge is still counted; abort overrides expiry
        if (edge_s && (cnt_r == CNT_MAX)) begin
          ovf_nx_s = 1'b1;
        end else if (edge_s) begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_nx_s = cnt_r;
        end
        if (abort) begin
          state_nx_s = IDLE;
        end else if (timer_r == {TMR_W{1'b0}}) begin
          state_nx_s = DONE;
        end else begin
          timer_nx_s = timer_r - TMR_W'(1);
        end
      end
      DONE: begin
        if (res.result_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, timer and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      timer_r <= {TMR_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      timer_r <= timer_nx_s;
      cnt_r   <= cnt_nx_s;
      ovf_r   <= ovf_nx_s;
    end
  end

  // Registered outputs, derived from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro_activate_r <= 1'b0;
      busy_r        <= 1'b0;
      valid_r       <= 1'b0;
      res_count_r   <= {CNT_W{1'b0}};
      res_ovf_r     <= 1'b0;
`ifdef RO_SNAPSHOT_EN
      snap_r        <= {RO_STAGES{1'b0}};
`endif
    end else begin
      ro_activate_r <= (state_nx_s == WARMUP) || (state_nx_s == MEASURE);
      busy_r        <= (state_nx_s != IDLE);
      valid_r       <= (state_nx_s == DONE);
      if ((state_r == MEASURE) && (state_nx_s == DONE)) begin
        res_count_r <= cnt_nx_s;
        res_ovf_r   <= ovf_nx_s;
`ifdef RO_SNAPSHOT_EN
        snap_r      <= stage_buf;
`endif
      end
    end
  end

  assign ro_activate      = ro_activate_r;
  assign busy             = busy_r;
  assign res.result_valid = valid_r;
  assign res.result_count = res_count_r;
  assign res.result_ovf   = res_ovf_r;
`ifdef RO_SNAPSHOT_EN
  assign res.result_snapshot = snap_r;
`endif

endmodule

// File: tb/tb_ro_freq_counter.sv
// Randomized self-checking bench for ro_freq_counter against a waveform-level
// edge-counting model.
module tb_ro_freq_counter;

  localparam int S    = 4;
  localparam int W    = 16;
  localparam int CW   = 3;
  localparam int CMAX = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ro_out = 1'b0;
  logic ro_activate;
  logic busy;
  logic [18:0] stage_buf = 19'h0;

  int total = 0;
  int bad = 0;
  bit wave [0:63];

  ro_freq_counter_if #(.CNT_W(CW)) rif ();

  ro_freq_counter #(
    .SETTLE_CYCLES (S),
    .WINDOW_CYCLES (W),
    .CNT_W         (CW),
    .TMR_W         (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .ro_out      (ro_out),
    .ro_activate (ro_activate),
    .busy        (busy),
`ifdef RO_SNAPSHOT_EN
    .stage_buf   (stage_buf),
`endif
    .res         (rif)
  );

  always #5 clk = ~clk;

  // Rises driven after edge e are counted iff they fall inside the gate window
  function automatic void model(output int cnt, output bit ovf);
    int rises = 0;
    for (int e = S - 1; e <= S + W - 2; e++)
      if (wave[e] && !wave[e-1]) rises++;
    ovf = (rises > CMAX);
    cnt = ovf ? CMAX : rises;
  endfunction

  task automatic fill_square(input int period);
    for (int k = 0; k < 64; k++) wave[k] = ((k % period) >= (period / 2));
  endtask

  task automatic fill_random(input int max_hold);
    bit lvl = 1'b0;
    int hold = 0;
    for (int k = 0; k < 64; k++) begin
      if (hold == 0) begin
        lvl  = ~lvl;
        hold = $urandom_range(max_hold, 1);
      end
      wave[k] = lvl;
      hold--;
    end
  endtask

  task automatic run_measure(output int valid_edge, output bit act1, output bit act_done);
    @(posedge clk); #1;
    start = 1'b1;
    ro_out = wave[0];
    valid_edge = -1;
    act1 = 1'b0;
    act_done = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ro_out = wave[k];
      stage_buf = (k == S + W) ? 19'h2AAAA : 19'h0;
      if (k == 1) act1 = ro_activate;
      if (rif.result_valid) begin
        valid_edge = k;
        act_done = ro_activate;
        break;
      end
    end
    ro_out = 1'b0;
    stage_buf = 19'h0;
  endtask

  task automatic accept_result();
    rif.result_ready = 1'b1;
    @(posedge clk); #1;
    rif.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ro_activate, busy, rif.result_valid, rif.result_ovf} !== 4'b0000 || rif.result_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_outputs: got act=%b busy=%b valid=%b ovf=%b cnt=%0d expected all 0",
               ro_activate, busy, rif.result_valid, rif.result_ovf, rif.result_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_basic();
    int ve, ec; bit a1, ad, eo;
    fill_square(4);
    model(ec, eo);
    run_measure(ve, a1, ad);
    total++;
    if (a1 !== 1'b1) begin bad++; $display("FAIL basic_activate: got %b expected 1", a1); end
    total++;
    if (ve !== 1 + S + W) begin bad++; $display("FAIL basic_latency: got %0d expected %0d", ve, 1 + S + W); end
    total++;
    if (rif.result_count !== 3'(ec) || rif.result_count !== 3'd4 || rif.result_ovf !== 1'b0)
      begin bad++; $display("FAIL basic_count: got %0d/%b expected 4/0", rif.result_count, rif.result_ovf); end
    total++;
    if (ad !== 1'b0) begin bad++; $display("FAIL basic_act_done: got %b expected 0", ad); end
`ifdef RO_SNAPSHOT_EN
    total++;
    if (rif.result_snapshot !== 19'h2AAAA)
      begin bad++; $display("FAIL basic_snapshot: got %h expected 2aaaa", rif.result_snapshot); end
`endif
    accept_result();
    total++;
    if (rif.result_valid !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL basic_accept: valid=%b busy=%b expected 0/0", rif.result_valid, busy); end
  endtask

  task automatic test_saturation();
    int ve, ec; bit a1, ad, eo;
    fill_square(2);
    model(ec, eo);
    run_measure(ve, a1, ad);
    total++;
    if (ve !== 1 + S + W || rif.result_count !== 3'(ec) || rif.result_ovf !== eo || eo !== 1'b1)
      begin bad++; $display("FAIL sat_result: got edge=%0d cnt=%0d ovf=%b expected %0d/%0d/%b",
                            ve, rif.result_count, rif.result_ovf, 1 + S + W, ec, eo); end
    accept_result();
  endtask

  task automatic test_backpressure();
    int ve, ec; bit a1, ad, eo;
    fill_square(4);
    model(ec, eo);
    run_measure(ve, a1, ad);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start = (i == 3);
      total++;
      if (rif.result_valid !== 1'b1 || busy !== 1'b1 || rif.result_count !== 3'(ec))
        begin bad++; $display("FAIL bp_hold[%0d]: valid=%b busy=%b cnt=%0d expected 1/1/%0d",
                              i, rif.result_valid, busy, rif.result_count, ec); end
    end
    start = 1'b1;
    accept_result();
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || rif.result_valid !== 1'b0)
      begin bad++; $display("FAIL bp_accept: busy=%b valid=%b expected 0/0", busy, rif.result_valid); end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || ro_activate !== 1'b0)
      begin bad++; $display("FAIL bp_no_queue: busy=%b act=%b expected 0/0", busy, ro_activate); end
  endtask

  task automatic test_abort();
    int ve, ec; bit a1, ad, eo, saw_valid;
    fill_square(4);
    @(posedge clk); #1;
    start = 1'b1;
    ro_out = wave[0];
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ro_out = wave[k];
      abort = (k == 9);
    end
    total++;
    if (ro_activate !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL abort_stop: act=%b busy=%b expected 0/0", ro_activate, busy); end
    saw_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (rif.result_valid === 1'b1) saw_valid = 1'b1;
    end
    ro_out = 1'b0;
    total++;
    if (saw_valid !== 1'b0) begin bad++; $display("FAIL abort_no_result: valid seen=%b expected 0", saw_valid); end
    model(ec, eo);
    run_measure(ve, a1, ad);
    total++;
    if (ve !== 1 + S + W || rif.result_count !== 3'd4 || rif.result_count !== 3'(ec))
      begin bad++; $display("FAIL abort_rerun: edge=%0d cnt=%0d expected %0d/4", ve, rif.result_count, 1 + S + W); end
    accept_result();
  endtask

  task automatic test_reset_mid();
    int ve, ec; bit a1, ad, eo;
    fill_square(4);
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ro_out = wave[k];
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ro_activate, busy, rif.result_valid, rif.result_ovf} !== 4'b0000 || rif.result_count !== 3'd0)
      begin bad++; $display("FAIL rst_mid_async: act=%b busy=%b valid=%b ovf=%b cnt=%0d expected all 0",
                            ro_activate, busy, rif.result_valid, rif.result_ovf, rif.result_count); end
    ro_out = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || ro_activate !== 1'b0)
      begin bad++; $display("FAIL rst_mid_idle: busy=%b act=%b expected 0/0", busy, ro_activate); end
    model(ec, eo);
    run_measure(ve, a1, ad);
    total++;
    if (ve !== 1 + S + W || rif.result_count !== 3'(ec))
      begin bad++; $display("FAIL rst_mid_rerun: edge=%0d cnt=%0d expected %0d/%0d", ve, rif.result_count, 1 + S + W, ec); end
    accept_result();
  endtask

  task automatic test_random();
    int ve, ec; bit a1, ad, eo;
    for (int it = 0; it < 10; it++) begin
      fill_random((it < 5) ? 3 : 8);
      model(ec, eo);
      run_measure(ve, a1, ad);
      total++;
      if (ve !== 1 + S + W || rif.result_count !== 3'(ec) || rif.result_ovf !== eo)
        begin bad++; $display("FAIL random[%0d]: edge=%0d cnt=%0d ovf=%b expected %0d/%0d/%b",
                              it, ve, rif.result_count, rif.result_ovf, 1 + S + W, ec, eo); end
      accept_result();
      repeat ($urandom_range(3, 0)) @(posedge clk);
    end
  endtask

  initial begin
    rif.result_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
